psum_collector: RTL and testbench

//  Output end of the weight-stationary systolic array. Captures the column-skewed partial

---
 rtl/psum_collector_if.sv | 39 +++
 rtl/psum_collector.sv | 241 ++++++++++++++++++++++++
 tb/tb_psum_collector.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_collector_if.sv
// rtl/psum_collector_if.sv - bundle of control, psum input and result stream signals for psum_collector
//
// Purpose: groups every non-clock/non-reset signal of psum_collector so that the
//   collector and its driver share one typed connection.
// Ports (signals):
//   tile_start/tile_rows/acc_en/tile_last  pass control, driven by the sequencer
//   in_valid/in_sum                        skewed bottom-row psums from the array
//   out_valid/out_ready/out_data/out_last  aligned result stream to the writer
//   busy/err                               status
// Modports: master = sequencer/writer side, slave = collector side.

interface psum_collector_if #(
  parameter int ARRAYWIDTH = 8,
  parameter int PSUM_W     = 32,
  parameter int CNT_W      = 5
);
  logic                         tile_start;
  logic [CNT_W-1:0]             tile_rows;
  logic                         acc_en;
  logic                         tile_last;
  logic                         in_valid;
  logic [ARRAYWIDTH*PSUM_W-1:0] in_sum;
  logic                         busy;
  logic                         out_valid;
  logic                         out_ready;
  logic [ARRAYWIDTH*PSUM_W-1:0] out_data;
  logic                         out_last;
  logic                         err;

  modport master (
    output tile_start, tile_rows, acc_en, tile_last, in_valid, in_sum, out_ready,
    input  busy, out_valid, out_data, out_last, err
  );

  modport slave (
    input  tile_start, tile_rows, acc_en, tile_last, in_valid, in_sum, out_ready,
    output busy, out_valid, out_data, out_last, err
  );
endinterface

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - deskews systolic-array psums, accumulates over K-tiles, drains result vectors
//
// Purpose: captures column-skewed partial sums from the bottom PE row, realigns
//   them into row vectors, overwrites or accumulates them into a local buffer
//   across passes, and streams the buffer out after the final pass.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-low
//   bus.slave  tile_start/tile_rows/acc_en/tile_last  pass control (sampled on tile_start)
//              in_valid/in_sum                        skewed psum input, lane j delayed j cycles
//              out_valid/out_ready/out_data/out_last  result vector stream
//              busy                                   FSM not idle
//              err                                    sticky protocol error

module psum_collector #(
  parameter int ARRAYWIDTH = 8,
  parameter int PSUM_W     = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 5
) (
  input  logic            clk,
  input  logic            rst,
  psum_collector_if.slave bus
);

  localparam int DW    = ARRAYWIDTH * PSUM_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Pass controls latched on an accepted tile_start
  logic [CNT_W-1:0] rows_q;
  logic             acc_q;
  logic             last_q;

  logic [CNT_W-1:0] inj_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;

  // Bit k set: a vector injected k+1 cycles ago is still in flight
  logic [ARRAYWIDTH-2:0] vld_sr;

  logic [DW-1:0] aligned;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem [DEPTH];

  logic          out_valid_q;
  logic          out_last_q;
  logic [DW-1:0] out_data_q;
  logic          err_q;

  logic rows_legal;
  logic start_ok;
  logic start_bad;
  logic inj_ok;
  logic inj_bad;
  logic wr_en;
  logic wr_done;
  logic drain_first;
  logic xfer;
  logic drain_next;
  logic drain_done;
  logic busy_c;

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = wr_cnt[IDX_W-1:0];
  assign rd_idx = rd_cnt[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Deskew: lane j is delayed ARRAYWIDTH-1-j cycles so every lane of a vector
  // lines up in the cycle the last lane arrives. Lane ARRAYWIDTH-1 is used live.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < ARRAYWIDTH; j++) begin : g_lane
    if (j == ARRAYWIDTH - 1) begin : g_direct
      assign aligned[j*PSUM_W +: PSUM_W] = bus.in_sum[j*PSUM_W +: PSUM_W];
    end else begin : g_delay
      localparam int D = ARRAYWIDTH - 1 - j;
      logic [PSUM_W-1:0] dl [D];

      always_ff @(posedge clk) begin
        dl[0] <= bus.in_sum[j*PSUM_W +: PSUM_W];
        for (int k = 1; k < D; k++) begin
          dl[k] <= dl[k-1];
        end
      end

      assign aligned[j*PSUM_W +: PSUM_W] = dl[D-1];
    end
  end

  // Lane-wise overwrite or wrapping accumulate into the addressed entry
  always_comb begin
    wr_data = aligned;
    if (acc_q) begin
      for (int j = 0; j < ARRAYWIDTH; j++) begin
        wr_data[j*PSUM_W +: PSUM_W] = mem[wr_idx][j*PSUM_W +: PSUM_W]
                                    + aligned[j*PSUM_W +: PSUM_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (wr_done) state_nxt = last_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (drain_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs and datapath strobes
  always_comb begin
    rows_legal  = (bus.tile_rows != '0) && (bus.tile_rows <= DEPTH_C);
    start_ok    = 1'b0;
    start_bad   = 1'b0;
    inj_ok      = 1'b0;
    wr_en       = 1'b0;
    drain_first = 1'b0;
    busy_c      = (state != S_IDLE);

    if (bus.tile_start) begin
      if ((state == S_IDLE) && rows_legal) start_ok  = 1'b1;
      else                                 start_bad = 1'b1;
    end

    if (state == S_COLLECT) begin
      inj_ok = bus.in_valid && (inj_cnt != rows_q);
      wr_en  = vld_sr[ARRAYWIDTH-2];
    end

    // out_valid is low only in the first DRAIN cycle, which primes entry 0
    if (state == S_DRAIN) begin
      drain_first = !out_valid_q;
    end

    inj_bad    = bus.in_valid && !inj_ok;
    wr_done    = wr_en && ((wr_cnt + ONE) == rows_q);
    xfer       = out_valid_q && bus.out_ready;
    drain_next = xfer && !out_last_q;
    drain_done = xfer && out_last_q;
  end

  // ---------------------------------------------------------------------------
  // Counters, skew valid tracking, output stream registers, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      rows_q      <= '0;
      acc_q       <= 1'b0;
      last_q      <= 1'b0;
      inj_cnt     <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      vld_sr      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      vld_sr[0] <= inj_ok;
      for (int k = 1; k < ARRAYWIDTH - 1; k++) begin
        vld_sr[k] <= vld_sr[k-1];
      end

      if (start_ok) begin
        rows_q  <= bus.tile_rows;
        acc_q   <= bus.acc_en;
        last_q  <= bus.tile_last;
        inj_cnt <= '0;
        wr_cnt  <= '0;
        rd_cnt  <= '0;
      end else begin
        if (inj_ok) inj_cnt <= inj_cnt + ONE;
        if (wr_en)  wr_cnt  <= wr_cnt + ONE;
      end

      if (start_bad || inj_bad) begin
        err_q <= 1'b1;
      end

      // rd_cnt always points at the next entry to present
      if (drain_first) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mem[0];
        out_last_q  <= (rows_q == ONE);
        rd_cnt      <= ONE;
      end else if (drain_next) begin
        out_data_q  <= mem[rd_idx];
        out_last_q  <= (rd_cnt == (rows_q - ONE));
        rd_cnt      <= rd_cnt + ONE;
      end else if (drain_done) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  // Result buffer: not reset; a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - randomized self-checking bench for psum_collector

module tb_psum_collector;

  localparam int W     = 4;
  localparam int P     = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  psum_collector_if #(.ARRAYWIDTH(W), .PSUM_W(P), .CNT_W(CNT_W)) ifc ();

  psum_collector #(.ARRAYWIDTH(W), .PSUM_W(P), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int errors = 0;

  // Reference: buffer contents as a plain array of lane values
  logic [P-1:0] model [DEPTH][W];
  logic [P-1:0] fv    [16][W];
  int           ft    [16];
  bit           cur_acc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.tile_start = 1'b0;
    ifc.tile_rows  = '0;
    ifc.acc_en     = 1'b0;
    ifc.tile_last  = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.in_sum     = '0;
    ifc.out_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic start_tile(input int rows, input bit acc, input bit last);
    ifc.tile_start = 1'b1;
    ifc.tile_rows  = CNT_W'(rows);
    ifc.acc_en     = acc;
    ifc.tile_last  = last;
    cur_acc        = acc;
    step();
    ifc.tile_start = 1'b0;
  endtask

  // Feeds n vectors skewed (lane j one cycle later per j); unused lanes get noise.
  // extra adds one surplus in_valid right after the last injection.
  task automatic feed(input int n, input bit gaps, input bit rnd, input bit extra);
    int t = 0;
    int t_end;
    int ext_t;
    bit hit;
    for (int i = 0; i < n; i++) begin
      ft[i] = t;
      t += gaps ? 1 + int'($urandom_range(2, 0)) : 1;
      if (rnd) for (int j = 0; j < W; j++) fv[i][j] = $urandom;
    end
    ext_t = ft[n-1] + 1;
    t_end = ft[n-1] + W - 1;
    for (int c = 0; c <= t_end; c++) begin
      hit = extra && (c == ext_t);
      for (int j = 0; j < W; j++) ifc.in_sum[j*P +: P] = $urandom;
      for (int i = 0; i < n; i++) begin
        if (ft[i] == c) hit = 1'b1;
        for (int j = 0; j < W; j++)
          if (ft[i] + j == c) ifc.in_sum[j*P +: P] = fv[i][j];
      end
      ifc.in_valid = hit;
      step();
    end
    ifc.in_valid = 1'b0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < W; j++)
        model[i][j] = cur_acc ? model[i][j] + fv[i][j] : fv[i][j];
  endtask

  // mode 0: ready always; 1: random ready; 2: 3 stall cycles then full rate;
  // 3: as 2 plus a tile_start pulse during the first stall
  task automatic drain_check(input int rows, input int mode);
    int idx = 0;
    int cyc = 0;
    int stall = 0;
    bit ready;
    bit prev_stall = 1'b0;
    bit phase_hi = 1'b0;
    logic [W*P-1:0] prev_data;
    logic prev_last;
    logic [W*P-1:0] expv;
    while (idx < rows && cyc < 300) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(1, 0));
        default: ready = (stall >= 3);
      endcase
      ifc.tile_start = (mode == 3) && ifc.out_valid && (stall == 0) && !ready;
      ifc.out_ready  = ready;
      if (prev_stall) begin
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== prev_data || ifc.out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   ifc.out_valid, ifc.out_data, ifc.out_last, prev_data, prev_last);
        end
      end
      if (phase_hi) begin
        checks++;
        if (ifc.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL full_rate: out_valid=%b at entry %0d, required 1", ifc.out_valid, idx);
        end
      end
      if (ifc.out_valid === 1'b1 && ready) begin
        for (int j = 0; j < W; j++) expv[j*P +: P] = model[idx][j];
        checks++;
        if (ifc.out_data !== expv) begin
          errors++;
          $display("FAIL drain_data[%0d]: got %h, required %h", idx, ifc.out_data, expv);
        end
        checks++;
        if (ifc.out_last !== (idx == rows - 1)) begin
          errors++;
          $display("FAIL drain_last[%0d]: got %b, required %b", idx, ifc.out_last, idx == rows - 1);
        end
        idx++;
        if (mode >= 2) phase_hi = (idx < rows);
      end
      prev_stall = (ifc.out_valid === 1'b1) && !ready;
      prev_data  = ifc.out_data;
      prev_last  = ifc.out_last;
      if (ifc.out_valid === 1'b1 && !ready) stall++;
      step();
      cyc++;
    end
    ifc.out_ready  = 1'b0;
    ifc.tile_start = 1'b0;
    checks++;
    if (idx != rows) begin
      errors++;
      $display("FAIL drain_count: got %0d vectors, required %0d (timeout)", idx, rows);
    end
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: out_valid=%b busy=%b, required 0 0", ifc.out_valid, ifc.busy);
    end
  endtask

  task automatic set_scn1();
    for (int j = 0; j < W; j++) begin
      fv[0][j] = P'(j + 1);
      fv[1][j] = P'(j + 5);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    checks++;
    if (ifc.busy !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.out_last !== 1'b0 ||
        ifc.err !== 1'b0 || ifc.out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b valid=%b last=%b err=%b data=%h, required all 0",
               ifc.busy, ifc.out_valid, ifc.out_last, ifc.err, ifc.out_data);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_overwrite_drain();
    set_scn1();
    start_tile(2, 1'b0, 1'b1);
    feed(2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL ovw_busy: got %b, required 1", ifc.busy);
    end
    drain_check(2, 0);
    checks++;
    if (ifc.err !== 1'b0) begin
      errors++;
      $display("FAIL ovw_err: got %b, required 0", ifc.err);
    end
  endtask

  task automatic test_accumulate_wrap();
    fv[0][0] = 32'd10; fv[0][1] = 32'hFFFF_FFFF; fv[0][2] = 32'd0; fv[0][3] = 32'd0;
    start_tile(1, 1'b0, 1'b0);
    feed(1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ifc.busy !== 1'b0 || ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL acc_mid_idle: busy=%b valid=%b, required 0 0", ifc.busy, ifc.out_valid);
    end
    fv[0][0] = 32'd5; fv[0][1] = 32'd2; fv[0][2] = 32'd0; fv[0][3] = 32'd0;
    start_tile(1, 1'b1, 1'b1);
    feed(1, 1'b0, 1'b0, 1'b0);
    drain_check(1, 0);
  endtask

  task automatic test_random_passes();
    for (int r = 0; r < 3; r++) begin
      int rows = 1 + int'($urandom_range(DEPTH - 1, 0));
      for (int p = 0; p < 3; p++) begin
        start_tile(rows, p != 0, p == 2);
        feed(rows, 1'b1, 1'b1, 1'b0);
      end
      drain_check(rows, 1);
    end
  endtask

  task automatic test_backpressure();
    start_tile(5, 1'b0, 1'b1);
    feed(5, 1'b0, 1'b1, 1'b0);
    drain_check(5, 2);
  endtask

  task automatic test_back_to_back();
    start_tile(DEPTH, 1'b0, 1'b1);
    feed(DEPTH, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ifc.err !== 1'b1 || ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overflow: err=%b busy=%b, required 1 1", ifc.err, ifc.busy);
    end
    drain_check(DEPTH, 0);
    do_reset();
  endtask

  task automatic test_protocol();
    ifc.in_valid = 1'b1;
    step();
    ifc.in_valid = 1'b0;
    checks++;
    if (ifc.err !== 1'b1 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_valid: err=%b busy=%b, required 1 0", ifc.err, ifc.busy);
    end
    do_reset();
    start_tile(0, 1'b0, 1'b1);
    checks++;
    if (ifc.err !== 1'b1 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL rows_zero: err=%b busy=%b, required 1 0", ifc.err, ifc.busy);
    end
    do_reset();
    start_tile(DEPTH + 1, 1'b0, 1'b1);
    checks++;
    if (ifc.err !== 1'b1 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL rows_over: err=%b busy=%b, required 1 0", ifc.err, ifc.busy);
    end
    do_reset();
    start_tile(2, 1'b0, 1'b1);
    feed(2, 1'b1, 1'b1, 1'b0);
    drain_check(2, 3);
    checks++;
    if (ifc.err !== 1'b1) begin
      errors++;
      $display("FAIL drain_start: err=%b, required 1", ifc.err);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    start_tile(4, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_sum   = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    ifc.in_valid = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (ifc.busy !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.out_last !== 1'b0 ||
        ifc.err !== 1'b0 || ifc.out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b valid=%b last=%b err=%b data=%h, required all 0",
               ifc.busy, ifc.out_valid, ifc.out_last, ifc.err, ifc.out_data);
    end
    rst = 1'b1;
    step();
    set_scn1();
    start_tile(2, 1'b0, 1'b1);
    feed(2, 1'b0, 1'b0, 1'b0);
    drain_check(2, 0);
    checks++;
    if (ifc.err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_err: got %b, required 0", ifc.err);
    end
  endtask

  initial begin
    test_reset();
    test_overwrite_drain();
    test_accumulate_wrap();
    test_random_passes();
    test_backpressure();
    test_back_to_back();
    test_protocol();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
